// File: rtl/multi_event_sync.sv
// Multi-channel event synchroniser for the destination clock domain.
// Each channel: flop-chain synchroniser, optional glitch filter, selectable
// rise/fall/both edge detect, registered pulse, sticky pending flag and a
// saturating event counter. A shared warm-up window suppresses events that
// would otherwise be seen while the chains fill after reset.
module multi_event_sync #(
  parameter int NCH         = 4,
  parameter int SYNC_STAGES = 2,
  parameter int FILT_CYCLES = 0,
  parameter int CNT_W       = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NCH-1:0]       async_in,
  input  logic [2*NCH-1:0]     edge_mode,
  input  logic [NCH-1:0]       pending_clr,
  input  logic                 cnt_clr,
  output logic [NCH-1:0]       event_pulse,
  output logic [NCH-1:0]       event_pending,
  output logic [NCH*CNT_W-1:0] event_cnt
);
  localparam int                WARM_LEN  = SYNC_STAGES + FILT_CYCLES + 1;
  localparam int                WARM_W    = $clog2(WARM_LEN + 1);
  localparam logic [WARM_W-1:0] WARM_INIT = WARM_W'(WARM_LEN);
  localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

  logic [WARM_W-1:0] r_warm;
  logic              w_warm;

  assign w_warm = (r_warm != '0);

  // Warm-up down-counter: nonzero while sync chains and filters settle.
  always_ff @(posedge clk) begin
    if (rst)         r_warm <= WARM_INIT;
    else if (w_warm) r_warm <= r_warm - WARM_W'(1);
  end

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_filt;
    logic                   r_prev;
    logic                   r_pulse;
    logic                   r_pend;
    logic [CNT_W-1:0]       r_cnt;
    logic                   w_sync;
    logic                   w_rise;
    logic                   w_fall;
    logic                   w_hit;

    assign w_sync = r_sync[SYNC_STAGES-1];

    // Plain flop chain; stage 0 takes the raw asynchronous level.
    always_ff @(posedge clk) begin
      if (rst) r_sync <= '0;
      else     r_sync <= {r_sync[SYNC_STAGES-2:0], async_in[i]};
    end

    if (FILT_CYCLES == 0) begin : g_nofilt
      // No filter: the filtered level is the sync output, one register later.
      always_ff @(posedge clk) begin
        if (rst) r_filt <= 1'b0;
        else     r_filt <= w_sync;
      end
    end else begin : g_filt
      localparam int            FW       = $clog2(FILT_CYCLES + 1);
      localparam logic [FW-1:0] FILT_MAX = FW'(FILT_CYCLES);
      logic [FW-1:0] r_fcnt;

      // Accept a new level only after it has differed for FILT_CYCLES+1
      // consecutive samples; any return to the old level restarts the count.
      always_ff @(posedge clk) begin
        if (rst) begin
          r_fcnt <= '0;
          r_filt <= 1'b0;
        end else if (w_warm) begin
          r_fcnt <= '0;
          r_filt <= w_sync;
        end else if (w_sync == r_filt) begin
          r_fcnt <= '0;
        end else if (r_fcnt == FILT_MAX) begin
          r_fcnt <= '0;
          r_filt <= w_sync;
        end else begin
          r_fcnt <= r_fcnt + FW'(1);
        end
      end
    end

    // Previous level; during warm-up it loads the same value as the filtered
    // level so a level already high at reset release never looks like an edge.
    always_ff @(posedge clk) begin
      if (rst)         r_prev <= 1'b0;
      else if (w_warm) r_prev <= w_sync;
      else             r_prev <= r_filt;
    end

    assign w_rise = r_filt & ~r_prev;
    assign w_fall = ~r_filt & r_prev;
    assign w_hit  = (edge_mode[2*i] & w_rise) | (edge_mode[2*i+1] & w_fall);

    // Registered one-cycle event pulse, held low during warm-up.
    always_ff @(posedge clk) begin
      if (rst) r_pulse <= 1'b0;
      else     r_pulse <= w_hit & ~w_warm;
    end

    // Sticky pending flag; a pulse wins over a simultaneous clear.
    always_ff @(posedge clk) begin
      if (rst)          r_pend <= 1'b0;
      else if (!w_warm) r_pend <= (r_pend & ~pending_clr[i]) | r_pulse;
    end

    // Saturating event counter; clear together with a pulse leaves a count of 1.
    always_ff @(posedge clk) begin
      if (rst) begin
        r_cnt <= '0;
      end else if (!w_warm) begin
        if (r_pulse) begin
          if (cnt_clr)               r_cnt <= CNT_W'(1);
          else if (r_cnt != CNT_MAX) r_cnt <= r_cnt + CNT_W'(1);
        end else if (cnt_clr) begin
          r_cnt <= '0;
        end
      end
    end

    assign event_pulse[i]               = r_pulse;
    assign event_pending[i]             = r_pend;
    assign event_cnt[i*CNT_W +: CNT_W]  = r_cnt;
  end

endmodule

// File: doc/multi_event_sync.md
Name: multi_event_sync

Overview:
- Multi-channel event synchroniser for the destination clock domain; the generalised successor of the single-channel low-to-high event crossing.
- Each channel takes an asynchronous level and passes it through a parametrised flop chain and an optional glitch filter.
- Each channel then detects rise, fall or both edges, as selected per channel.
- Each channel emits a one-cycle pulse, a sticky pending flag and a saturating event count.

Parameters:
- NCH, 4, number of independent channels (min 1)
- SYNC_STAGES, 2, synchroniser depth (min 2)
- FILT_CYCLES, 0, glitch-filter stability length in clk cycles; 0 disables the filter
- CNT_W, 8, per-channel event counter width (min 1)

Ports:
- clk  in  1  destination-domain clock
- rst  in  1  synchronous active-high reset
- async_in  in  NCH  asynchronous level inputs, one per channel
- edge_mode  in  2*NCH  per channel [2i+1:2i]: 00 none, 01 rise, 10 fall, 11 both
- pending_clr  in  NCH  per-channel clear of event_pending
- cnt_clr  in  1  clears all event counters
- event_pulse  out  NCH  one-cycle registered event pulse
- event_pending  out  NCH  sticky event flag
- event_cnt  out  NCH*CNT_W  channel i count at [i*CNT_W +: CNT_W]

Behaviour:
Clocking and reset:
- Single clock.
- Reset is synchronous and active-high; ports are clk and rst.
- While rst is high on a clk edge, all flops clear to 0: sync chains, filter counters, filtered level, previous level, event_pulse, event_pending, event_cnt.
- A warm-up counter is loaded with SYNC_STAGES+FILT_CYCLES+1.

Warm-up:
- The warm-up counter decrements every cycle after reset.
- While it is nonzero:
  - event_pulse is forced to 0.
  - pending and count are not updated.
  - The filtered level copies the sync output directly.
  - The previous-level register tracks the filtered level.
- Effect: an input already high at reset release never produces an event.

Sync chain:
- SYNC_STAGES flops per channel; sync_out is the last stage.
- No logic between stages.

Filter:
- FILT_CYCLES=0: the filtered level equals sync_out.
- FILT_CYCLES>0: per-channel counter of width clog2(FILT_CYCLES+1).
  - The counter increments while sync_out differs from the filtered level.
  - It resets to 0 when they match.
  - When the counter reaches FILT_CYCLES, the filtered level takes sync_out and the counter resets.
  - A glitch shorter than FILT_CYCLES cycles at sync_out never changes the filtered level.

Edge detection:
- prev <= filtered every cycle.
- rise = filtered & ~prev; fall = ~filtered & prev.
- hit = (mode[0] & rise) | (mode[1] & fall).
- event_pulse <= hit (registered), and is high for exactly one cycle per qualifying edge.

Latency and rate:
- An async_in transition meeting setup at edge E0 produces event_pulse high in the cycle after edge E0 + SYNC_STAGES + FILT_CYCLES + 1.
- With defaults, event_pulse is high after the 3rd edge following capture.
- Back-to-back edges on the filtered level, i.e. an input toggling each cycle with FILT_CYCLES=0 and mode 11, give one pulse per cycle with none lost.

edge_mode:
- edge_mode is sampled every cycle with no pipeline; a change affects hits from the same cycle.
- Changing mode never creates a pulse by itself.

Pending flag:
- event_pending[i] <= (event_pending[i] & ~pending_clr[i]) | event_pulse[i].
- If a pulse and a clear arrive in the same cycle, set wins.

Counter:
- cnt_clr and a pulse in the same cycle: count becomes 1.
- cnt_clr alone: count becomes 0.
- Pulse alone: count increments, saturating at 2^CNT_W-1 with no wrap.
- Counter updates use the registered event_pulse, so the count and pending update one cycle after the pulse is visible.

Reset mid-operation:
- Reset asserted with pulses in flight drops them.
- All outputs read 0 in the cycle after the reset edge, and warm-up restarts.

Channel independence:
- Channels are fully independent.
- Simultaneous events on several channels are all reported in the same cycle.

Test Plan:
- Reset release with async_in=4'b0101 held high from before reset → no event_pulse, pending=0, all counts 0 after warm-up.
- Defaults, mode all 01, ch0 rises 10 cycles after warm-up → event_pulse[0] high exactly 1 cycle, 3 edges after capture. Next cycle: pending[0]=1, cnt0=1. Falling edge later gives no pulse.
- Mode 11 on ch2, input toggles every 4 cycles for 20 edges → 20 single-cycle pulses, cnt2=20. Then pending_clr[2] coinciding with a pulse → pending[2] remains 1.
- FILT_CYCLES=3, ch1 high glitch of 2 cycles → no pulse. High held for 5 cycles → one pulse at latency SYNC_STAGES+4 edges.
- CNT_W=3, 9 rising events on ch3 → cnt3 saturates at 7. Then cnt_clr in the same cycle as a pulse → cnt3=1.
- Rising edges on all 4 channels in the same cycle, with rst asserted 1 cycle after the pulses → all 4 pulses seen once, then all outputs 0, and no events during the new warm-up.
